// File: rtl/wb_merge.sv
`default_nettype none
// ============================================================================
// Module   : wb_merge
// Purpose  : Writeback stage. Holds the M->W pipeline register (with load
//            extension and result selection done ahead of it) and merges
//            out-of-band MDU results into the single GRF write port through
//            a small FIFO. The pipeline always wins the port; queued MDU
//            results drain on idle pipeline cycles.
// Ports    : clk, reset (async, active-high)
//            regwrite_m/a3_m/aluout_m/dmdata_m/pc8_m/memtoreg_m/ldext_m/
//            boff_m           - M-stage inputs
//            mdu_valid/mdu_a3/mdu_data, mdu_ready - MDU result handshake
//            rf_we/rf_a3/rf_wd - GRF write port
//            q_count          - MDU queue occupancy
// Revision : 1.0  initial release
// ============================================================================
module wb_merge #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int QDEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         regwrite_m,
    input  logic [AW-1:0]                a3_m,
    input  logic [DW-1:0]                aluout_m,
    input  logic [DW-1:0]                dmdata_m,
    input  logic [DW-1:0]                pc8_m,
    input  logic [1:0]                   memtoreg_m,
    input  logic [2:0]                   ldext_m,
    input  logic [1:0]                   boff_m,
    input  logic                         mdu_valid,
    input  logic [AW-1:0]                mdu_a3,
    input  logic [DW-1:0]                mdu_data,
    output logic                         mdu_ready,
    output logic                         rf_we,
    output logic [AW-1:0]                rf_a3,
    output logic [DW-1:0]                rf_wd,
    output logic [$clog2(QDEPTH+1)-1:0]  q_count
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [PW-1:0] c_last_ptr = PW'(QDEPTH - 1);
    localparam logic [CW-1:0] c_full_cnt = CW'(QDEPTH);

    // ------------------------------------------------------------------
    // Load extension and result selection (ahead of the W register)
    // ------------------------------------------------------------------
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [DW-1:0] w_ld;
    logic [DW-1:0] w_res_m;

    always_comb begin
        case (boff_m)
            2'd1:    w_byte = dmdata_m[15:8];
            2'd2:    w_byte = dmdata_m[23:16];
            2'd3:    w_byte = dmdata_m[31:24];
            default: w_byte = dmdata_m[7:0];
        endcase
        // Halves are addressed by boff_m[1] only; the low bit is ignored.
        w_half = boff_m[1] ? dmdata_m[31:16] : dmdata_m[15:0];
        case (ldext_m)
            3'd1:    w_ld = {{(DW-8){w_byte[7]}}, w_byte};
            3'd2:    w_ld = {{(DW-8){1'b0}}, w_byte};
            3'd3:    w_ld = {{(DW-16){w_half[15]}}, w_half};
            3'd4:    w_ld = {{(DW-16){1'b0}}, w_half};
            default: w_ld = dmdata_m;
        endcase
        case (memtoreg_m)
            2'd1:    w_res_m = w_ld;
            2'd2:    w_res_m = pc8_m;
            default: w_res_m = aluout_m;
        endcase
    end

    // ------------------------------------------------------------------
    // W pipeline register
    // ------------------------------------------------------------------
    logic          r_w_regwrite;
    logic [AW-1:0] r_w_a3;
    logic [DW-1:0] r_w_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_w_regwrite <= 1'b0;
            r_w_a3       <= '0;
            r_w_data     <= '0;
        end else begin
            r_w_regwrite <= regwrite_m;
            r_w_a3       <= a3_m;
            r_w_data     <= w_res_m;
        end
    end

    // ------------------------------------------------------------------
    // MDU result queue
    // ------------------------------------------------------------------
    logic [AW-1:0] r_q_a3    [QDEPTH];
    logic [DW-1:0] r_q_data  [QDEPTH];
    logic          r_q_valid [QDEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_pw;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_push_valid;
    logic [PW-1:0] w_rd_next;
    logic [PW-1:0] w_wr_next;

    assign w_pw      = r_w_regwrite && (r_w_a3 != '0);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_full_cnt);
    // Readiness is based on occupancy at the start of the cycle, so a full
    // queue refuses a push even on a cycle where it also pops.
    assign mdu_ready = !w_full;
    assign w_push    = mdu_valid && !w_full;
    assign w_pop     = !w_pw && !w_empty;
    // A push targeting the register being committed by the (younger)
    // pipeline instruction is dead on arrival; $0 is never a real write.
    assign w_push_valid = (mdu_a3 != '0) && !(w_pw && (mdu_a3 == r_w_a3));
    assign w_rd_next = (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
    assign w_wr_next = (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_a3[i]    <= '0;
                r_q_data[i]  <= '0;
                r_q_valid[i] <= 1'b0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Squash older queued results made stale by the pipeline write.
            for (int i = 0; i < QDEPTH; i++) begin
                if (w_pw && (r_q_a3[i] == r_w_a3)) begin
                    r_q_valid[i] <= 1'b0;
                end
            end
            if (w_push) begin
                r_q_a3[r_wr_ptr]    <= mdu_a3;
                r_q_data[r_wr_ptr]  <= mdu_data;
                r_q_valid[r_wr_ptr] <= w_push_valid;
                r_wr_ptr            <= w_wr_next;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign q_count = r_count;

    // ------------------------------------------------------------------
    // GRF write-port arbitration
    // ------------------------------------------------------------------
    always_comb begin
        rf_we = 1'b0;
        rf_a3 = '0;
        rf_wd = '0;
        if (w_pw) begin
            rf_we = 1'b1;
            rf_a3 = r_w_a3;
            rf_wd = r_w_data;
        end else if (!w_empty && r_q_valid[r_rd_ptr]) begin
            rf_we = 1'b1;
            rf_a3 = r_q_a3[r_rd_ptr];
            rf_wd = r_q_data[r_rd_ptr];
        end
    end

endmodule
`default_nettype wire
